// File: rtl/buzzer_arbiter.sv
// Fixed-priority arbiter that shares one buzzer pin between three tone requesters.
// Latency: ack/done/abort are registered pulses one cycle after the deciding edge.
module buzzer_arbiter #(
  parameter int PERIOD_W   = 18,
  parameter int DUR_W      = 26,
  parameter int GAP_CYCLES = 500000,
  parameter bit PREEMPT    = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [2:0]          req,
  input  logic [PERIOD_W-1:0] period0,
  input  logic [PERIOD_W-1:0] period1,
  input  logic [PERIOD_W-1:0] period2,
  input  logic [DUR_W-1:0]    dur0,
  input  logic [DUR_W-1:0]    dur1,
  input  logic [DUR_W-1:0]    dur2,
  output logic [2:0]          ack,
  output logic [2:0]          done,
  output logic [2:0]          abort,
  output logic                busy,
  output logic [1:0]          active_id,
  output logic                buzzer_pin
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

  state_t              state;
  logic [PERIOD_W-1:0] period_q;
  logic [PERIOD_W-1:0] tone_cnt;
  logic [DUR_W-1:0]    dur_q;
  logic [DUR_W-1:0]    dur_cnt;
  logic [GAP_W-1:0]    gap_cnt;

  logic [1:0]          win_id;
  logic [PERIOD_W-1:0] win_period;
  logic [DUR_W-1:0]    win_dur;
  logic                preempt_hit;
  logic                grant;

  always_comb begin
    win_id     = 2'd0;
    win_period = period0;
    win_dur    = dur0;
    if (req[0]) begin
      win_id     = 2'd0;
      win_period = period0;
      win_dur    = dur0;
    end else if (req[1]) begin
      win_id     = 2'd1;
      win_period = period1;
      win_dur    = dur1;
    end else if (req[2]) begin
      win_id     = 2'd2;
      win_period = period2;
      win_dur    = dur2;
    end
    if (win_dur == '0) begin
      win_dur = DUR_W'(1);
    end
    // active_id holds the playing index in PLAY, so a lower winner index means higher priority
    preempt_hit = PREEMPT && (req != 3'b000) && (win_id < active_id);
    grant       = ((state == IDLE) && (req != 3'b000)) ||
                  ((state == PLAY) && preempt_hit);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      period_q   <= '0;
      tone_cnt   <= '0;
      dur_q      <= '0;
      dur_cnt    <= '0;
      gap_cnt    <= '0;
      ack        <= '0;
      done       <= '0;
      abort      <= '0;
      busy       <= 1'b0;
      active_id  <= 2'd3;
      buzzer_pin <= 1'b0;
    end else begin
      ack   <= '0;
      done  <= '0;
      abort <= '0;
      if (grant) begin
        if (state == PLAY) begin
          abort <= 3'b001 << active_id;
        end
        period_q   <= win_period;
        dur_q      <= win_dur;
        ack        <= 3'b001 << win_id;
        active_id  <= win_id;
        tone_cnt   <= '0;
        dur_cnt    <= '0;
        buzzer_pin <= 1'b0;
        busy       <= 1'b1;
        state      <= PLAY;
      end else begin
        case (state)
          PLAY: begin
            if (dur_cnt == dur_q - DUR_W'(1)) begin
              done       <= 3'b001 << active_id;
              buzzer_pin <= 1'b0;
              active_id  <= 2'd3;
              tone_cnt   <= '0;
              dur_cnt    <= '0;
              gap_cnt    <= '0;
              if (GAP_CYCLES > 0) begin
                state <= GAP;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else begin
              dur_cnt <= dur_cnt + DUR_W'(1);
              if (period_q == '0) begin
                buzzer_pin <= 1'b0;
              end else if (tone_cnt == period_q - PERIOD_W'(1)) begin
                tone_cnt   <= '0;
                buzzer_pin <= ~buzzer_pin;
              end else begin
                tone_cnt <= tone_cnt + PERIOD_W'(1);
              end
            end
          end
          GAP: begin
            if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
              gap_cnt <= '0;
              busy    <= 1'b0;
              state   <= IDLE;
            end else begin
              gap_cnt <= gap_cnt + GAP_W'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/buzzer_arbiter.md
Name: buzzer_arbiter

Overview:
- Shares the single board buzzer pin between three sound requesters: alarm (0), key-click (1) and melody player (2).
- Each requester submits a tone: a half-period and a duration, both in clk cycles.
- The block grants requests by fixed priority, optionally preempts lower-priority tones, generates the square wave itself, and inserts a silent gap between consecutive tones.
- It sits between the sound sources and the top-level buzzer_pin output.

Parameters:
- PERIOD_W, 18, width of the half-period fields. Max 262143 covers C4 = 191113.
- DUR_W, 26, width of the duration fields. Max ≈ 0.67 s at 100 MHz.
- GAP_CYCLES, 500000, silent cycles after every completed or aborted tone. 0 means no gap.
- PREEMPT, 1, when 1 a higher-priority request aborts the tone being played.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req  in  3  level request per requester; bit 0 has highest priority
- period0, period1, period2  in  PERIOD_W each  half-period for requester n. 0 = rest (silence).
- dur0, dur1, dur2  in  DUR_W each  tone length for requester n. 0 is treated as 1.
- ack  out  3  one-cycle pulse: request n accepted and its fields latched
- done  out  3  one-cycle pulse: tone n played to completion
- abort  out  3  one-cycle pulse: tone n preempted
- busy  out  1  high in PLAY and GAP
- active_id  out  2  index of the tone playing; 3 when not in PLAY
- buzzer_pin  out  1  square-wave output to the buzzer

Behaviour:
- Reset:
  - rst_n low asynchronously forces state IDLE.
  - All counters clear to 0.
  - ack, done and abort go to 0; busy goes to 0; active_id goes to 3; buzzer_pin goes to 0.
  - Reset mid-tone silences the pin immediately and emits no done or abort.
- All outputs are registered.
- Winner = lowest set index of req.

State IDLE:
- If req != 0 at a rising edge:
  - latch period/dur of the winner (dur 0 becomes 1);
  - ack[winner] = 1 in the following cycle;
  - set active_id = winner;
  - clear tone_cnt and dur_cnt; pin = 0;
  - go to PLAY.
- Requests only assert on that edge; no ack is generated in any other cycle of IDLE.

State PLAY:
- Every cycle dur_cnt increments.
- If the latched period != 0:
  - tone_cnt increments;
  - when tone_cnt == period-1, tone_cnt returns to 0 and the pin toggles.
  - The pin therefore first goes high after `period` PLAY cycles, giving a full period of 2*period cycles.
- If the latched period == 0, the pin is held at 0.
- When dur_cnt == dur-1:
  - done[active_id] pulses;
  - pin goes to 0 and active_id goes to 3;
  - next state is GAP if GAP_CYCLES > 0, otherwise IDLE.
- Preemption, when PREEMPT = 1 and req has a set bit with index < active_id:
  - abort[old] and ack[new] pulse in the same cycle;
  - the new fields are latched, counters clear, pin = 0;
  - the block stays in PLAY with the new active_id and inserts no gap.
- If preemption and completion coincide on the same edge, preemption wins: abort is emitted, not done.
- Requests with index ≥ active_id wait.

State GAP:
- Pin is 0; gap_cnt counts 0..GAP_CYCLES-1, then the block goes to IDLE.
- Requests arriving during GAP are not acknowledged until IDLE, even if higher priority.

Requester contract:
- A requester holds its fields stable while req is high and drops req after ack.
- A req still high after its done is re-granted as a new tone.
- Changing the fields after ack has no effect on the tone being played.

Pulse exclusivity:
- At most one bit of done and at most one bit of abort is set in any cycle.
- ack is one-hot or zero.

Test Plan:
1. Single tone. GAP_CYCLES = 4, req = 3'b100, period2 = 3, dur2 = 20, req dropped after ack:
   - ack[2] one cycle after req;
   - pin rises after 3 PLAY cycles and toggles every 3 cycles;
   - done[2] after exactly 20 PLAY cycles; pin then 0;
   - busy stays high 4 more cycles.
2. Simultaneous requests. req = 3'b110 in IDLE:
   - ack[1] first; done[1];
   - then GAP, then ack[2] one cycle after GAP ends.
3. Preemption, PREEMPT = 1. Requester 2 playing (period 5, dur 100); req[0] raised at PLAY cycle 40:
   - abort[2] and ack[0] in the same cycle;
   - pin forced to 0, new tone starts with no gap;
   - no done[2] is ever emitted.
4. PREEMPT = 0, same stimulus as scenario 3:
   - requester 2 completes with done[2];
   - ack[0] only after GAP.
5. Rest and zero duration:
   - period1 = 0, dur1 = 10: pin stays 0 for 10 cycles, then done[1].
   - dur1 = 0: done[1] one cycle after ack.
6. Asynchronous reset. rst_n pulled low mid-PLAY between clock edges:
   - pin, busy and ack/done/abort go to 0 and active_id goes to 3 immediately;
   - after release, a fresh req is acknowledged normally.
